// File: rtl/replacer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : replacer_arbiter
// Description : Round-robin arbiter that shares one replacer_extend datapath
//               between N_CH requester channels. Each packet is defined by a
//               descriptor giving the number of vid bytes and cnt entries.
//               The granted channel's FIFOs are forwarded until both quotas
//               are consumed. The datapath is then drained and cleared with a
//               one-cycle reset before the next grant.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               clk_en            - global enable for all state
//               out_afull         - downstream almost-full (gates drain count)
//               desc_*            - per-channel show-ahead descriptor FIFOs
//                                   {vid_len[7:0], cnt_len[7:0]}, L => L+1
//               vid_*, cnt_*      - per-channel data FIFOs
//               last_sign         - per-channel sign forwarded to datapath
//               dp_*              - datapath-facing mux, strobes, reset_n
//               grant, busy       - one-hot grant, high outside arbitration
//               out_ch            - granted channel index (optional)
// Options     : define REPLACER_ARB_TAG_EN to add the out_ch tag output.
// Revision    : 1.0 - initial release
// ============================================================================
module replacer_arbiter #(
    parameter int N_CH      = 4,
    parameter int DRAIN_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    out_afull,
    input  logic [N_CH*16-1:0]      desc_in,
    input  logic [N_CH-1:0]         desc_empty,
    output logic [N_CH-1:0]         desc_rd,
    input  logic [N_CH*8-1:0]       vid_in,
    input  logic [N_CH-1:0]         vid_empty,
    output logic [N_CH-1:0]         vid_rd,
    input  logic [N_CH*8-1:0]       cnt_in,
    input  logic [N_CH-1:0]         cnt_empty,
    output logic [N_CH-1:0]         cnt_rd,
    input  logic [N_CH-1:0]         last_sign,
    output logic [7:0]              dp_vid,
    output logic [7:0]              dp_cnt,
    output logic                    dp_vid_empty,
    output logic                    dp_cnt_empty,
    output logic                    dp_last_sign,
    input  logic                    dp_vid_rd,
    input  logic                    dp_cnt_rd,
    input  logic                    dp_data_wr,
    output logic                    dp_rst_n,
    output logic [N_CH-1:0]         grant,
    output logic                    busy
`ifdef REPLACER_ARB_TAG_EN
    ,
    output logic [$clog2(N_CH)-1:0] out_ch
`endif
);

    localparam int c_IW = $clog2(N_CH);

    localparam logic [1:0] c_ARB   = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_CLR   = 2'd3;

    localparam logic [3:0] c_DRAIN_LAST = 4'(DRAIN_CYC - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [N_CH-1:0] r_grant;
    logic [c_IW-1:0] r_gidx;
    logic [c_IW-1:0] r_last;
    logic [8:0]      r_vid_rem;
    logic [8:0]      r_cnt_rem;
    logic [3:0]      r_drain_cnt;

    logic            w_found;
    logic [c_IW-1:0] w_win;
    logic [c_IW:0]   w_sum;
    logic [15:0]     w_win_desc;
    logic            w_vid_pop;
    logic            w_cnt_pop;
    logic            w_drain_inc;
    logic            w_drain_done;
    logic            w_quota_done;

    // ------------------------------------------------------------------------
    // Rotating-priority search. Offsets are walked from farthest to nearest
    // so the last hit (smallest offset from last_grant) wins without a break.
    // The sum is kept below 2*N_CH, so one conditional subtract is a modulo.
    // ------------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = N_CH; k >= 1; k--) begin
            w_sum = {1'b0, r_last} + (c_IW+1)'(k);
            if (w_sum >= (c_IW+1)'(N_CH)) begin
                w_sum = w_sum - (c_IW+1)'(N_CH);
            end
            if (!desc_empty[w_sum[c_IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[c_IW-1:0];
            end
        end
    end

    assign w_win_desc = desc_in[{w_win, 4'b0000} +: 16];

    // Pops are what the datapath actually consumes; the forced-empty view
    // already blocks reads once a quota is exhausted.
    assign w_vid_pop    = (r_state == c_RUN) & dp_vid_rd & ~dp_vid_empty;
    assign w_cnt_pop    = (r_state == c_RUN) & dp_cnt_rd & ~dp_cnt_empty;
    assign w_quota_done = (r_vid_rem == 9'd0) & (r_cnt_rem == 9'd0);

    assign w_drain_inc  = clk_en & ~out_afull & ~dp_data_wr;
    assign w_drain_done = (r_state == c_DRAIN) & w_drain_inc &
                          (r_drain_cnt == c_DRAIN_LAST);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (clk_en) begin
            case (r_state)
                c_ARB: begin
                    if (w_found) begin
                        w_state_nxt = c_RUN;
                    end
                end
                c_RUN: begin
                    if (w_quota_done) begin
                        w_state_nxt = c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    if (w_drain_done) begin
                        w_state_nxt = c_CLR;
                    end
                end
                c_CLR: begin
                    w_state_nxt = c_ARB;
                end
                default: begin
                    w_state_nxt = c_ARB;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs. Reads are suppressed while rst is high so that a reset
    // arriving mid-packet cannot pop a FIFO on the reset edge.
    // ------------------------------------------------------------------------
    always_comb begin
        desc_rd      = '0;
        vid_rd       = '0;
        cnt_rd       = '0;
        dp_vid       = '0;
        dp_cnt       = '0;
        dp_vid_empty = 1'b1;
        dp_cnt_empty = 1'b1;
        dp_last_sign = 1'b0;
        busy         = (r_state != c_ARB);
        dp_rst_n     = ~rst & (r_state != c_CLR);

        if ((r_state == c_ARB) && w_found && clk_en && !rst) begin
            desc_rd[w_win] = 1'b1;
        end

        if (r_state == c_RUN) begin
            dp_vid       = vid_in[{r_gidx, 3'b000} +: 8];
            dp_cnt       = cnt_in[{r_gidx, 3'b000} +: 8];
            dp_last_sign = last_sign[r_gidx];
            dp_vid_empty = vid_empty[r_gidx] | (r_vid_rem == 9'd0);
            dp_cnt_empty = cnt_empty[r_gidx] | (r_cnt_rem == 9'd0);
            if (!rst) begin
                vid_rd[r_gidx] = dp_vid_rd & ~dp_vid_empty;
                cnt_rd[r_gidx] = dp_cnt_rd & ~dp_cnt_empty;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Grant, quota counters and drain counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant     <= '0;
            r_gidx      <= '0;
            r_last      <= c_IW'(N_CH - 1);
            r_vid_rem   <= '0;
            r_cnt_rem   <= '0;
            r_drain_cnt <= '0;
        end else if (clk_en) begin
            case (r_state)
                c_ARB: begin
                    if (w_found) begin
                        r_grant   <= {{(N_CH-1){1'b0}}, 1'b1} << w_win;
                        r_gidx    <= w_win;
                        r_last    <= w_win;
                        r_vid_rem <= {1'b0, w_win_desc[15:8]} + 9'd1;
                        r_cnt_rem <= {1'b0, w_win_desc[7:0]} + 9'd1;
                    end
                end
                c_RUN: begin
                    if (w_vid_pop) begin
                        r_vid_rem <= r_vid_rem - 9'd1;
                    end
                    if (w_cnt_pop) begin
                        r_cnt_rem <= r_cnt_rem - 9'd1;
                    end
                end
                c_DRAIN: begin
                    // Any write restarts the quiet window; the counter is
                    // cleared on exit so the next packet starts from zero.
                    if (dp_data_wr) begin
                        r_drain_cnt <= '0;
                    end else if (w_drain_done) begin
                        r_drain_cnt <= '0;
                    end else if (w_drain_inc) begin
                        r_drain_cnt <= r_drain_cnt + 4'd1;
                    end
                end
                c_CLR: begin
                    r_grant <= '0;
                end
                default: begin
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign grant = r_grant;

`ifdef REPLACER_ARB_TAG_EN
    // The granted index is loaded at grant time and held through CLR, so it
    // is stable across every datapath write of the packet.
    assign out_ch = r_gidx;
`endif

endmodule
`default_nettype wire

// File: tb/tb_replacer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_replacer_arbiter
// Description : Directed self-checking bench for replacer_arbiter
//               (N_CH=4, DRAIN_CYC=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_replacer_arbiter;

    localparam int N_CH      = 4;
    localparam int DRAIN_CYC = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              clk_en;
    logic              out_afull;
    logic [N_CH*16-1:0] desc_in;
    logic [N_CH-1:0]   desc_empty;
    logic [N_CH-1:0]   desc_rd;
    logic [N_CH*8-1:0] vid_in;
    logic [N_CH-1:0]   vid_empty;
    logic [N_CH-1:0]   vid_rd;
    logic [N_CH*8-1:0] cnt_in;
    logic [N_CH-1:0]   cnt_empty;
    logic [N_CH-1:0]   cnt_rd;
    logic [N_CH-1:0]   last_sign;
    logic [7:0]        dp_vid;
    logic [7:0]        dp_cnt;
    logic              dp_vid_empty;
    logic              dp_cnt_empty;
    logic              dp_last_sign;
    logic              dp_vid_rd;
    logic              dp_cnt_rd;
    logic              dp_data_wr;
    logic              dp_rst_n;
    logic [N_CH-1:0]   grant;
    logic              busy;
`ifdef REPLACER_ARB_TAG_EN
    logic [1:0]        out_ch;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int pend[N_CH];
    int vid_pops[N_CH];
    int cnt_pops[N_CH];
    int desc_pops[N_CH];
    int grant_q[$];
    logic [N_CH-1:0] s_desc_rd;

    always #5 clk = ~clk;

    replacer_arbiter #(
        .N_CH      (N_CH),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .out_afull    (out_afull),
        .desc_in      (desc_in),
        .desc_empty   (desc_empty),
        .desc_rd      (desc_rd),
        .vid_in       (vid_in),
        .vid_empty    (vid_empty),
        .vid_rd       (vid_rd),
        .cnt_in       (cnt_in),
        .cnt_empty    (cnt_empty),
        .cnt_rd       (cnt_rd),
        .last_sign    (last_sign),
        .dp_vid       (dp_vid),
        .dp_cnt       (dp_cnt),
        .dp_vid_empty (dp_vid_empty),
        .dp_cnt_empty (dp_cnt_empty),
        .dp_last_sign (dp_last_sign),
        .dp_vid_rd    (dp_vid_rd),
        .dp_cnt_rd    (dp_cnt_rd),
        .dp_data_wr   (dp_data_wr),
        .dp_rst_n     (dp_rst_n),
        .grant        (grant),
        .busy         (busy)
`ifdef REPLACER_ARB_TAG_EN
        ,
        .out_ch       (out_ch)
`endif
    );

    // Pop counters sampled mid-cycle; inputs only change just after posedge.
    always @(negedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (vid_rd[i])  vid_pops[i]  = vid_pops[i] + 1;
            if (cnt_rd[i])  cnt_pops[i]  = cnt_pops[i] + 1;
            if (desc_rd[i]) begin
                desc_pops[i] = desc_pops[i] + 1;
                grant_q.push_back(i);
            end
        end
    end

    // One clock; descriptor FIFO model pops on desc_rd. Returns at posedge+2.
    task automatic tick;
        @(negedge clk);
        s_desc_rd = desc_rd;
        @(posedge clk);
        #1;
        for (int i = 0; i < N_CH; i++) begin
            if (s_desc_rd[i] && pend[i] > 0) pend[i] = pend[i] - 1;
            desc_empty[i] = (pend[i] == 0);
        end
        #1;
    endtask

    task automatic set_pend(input int ch, input int n, input logic [15:0] d);
        pend[ch] = n;
        desc_in[ch*16 +: 16] = d;
        desc_empty[ch] = (n == 0);
    endtask

    task automatic test_reset;
        rst = 1'b1; clk_en = 1'b1; out_afull = 1'b0;
        dp_vid_rd = 1'b0; dp_cnt_rd = 1'b0; dp_data_wr = 1'b0;
        desc_in = '0; desc_empty = '1;
        vid_in = 32'h43424140; cnt_in = 32'h83828180;
        vid_empty = '0; cnt_empty = '0; last_sign = 4'b0101;
        for (int i = 0; i < N_CH; i++) pend[i] = 0;
        tick; tick;
        n_checks++;
        if ({grant, busy, dp_rst_n} !== 6'b0000_0_0) begin
            n_fail++;
            $display("FAIL reset_state: grant/busy/rst_n got %b expected %b", {grant, busy, dp_rst_n}, 6'b0);
        end
        n_checks++;
        if ({desc_rd, vid_rd, cnt_rd} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_reads: got %h expected 000", {desc_rd, vid_rd, cnt_rd});
        end
        n_checks++;
        if ({dp_vid_empty, dp_cnt_empty, dp_vid, dp_cnt} !== {2'b11, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_dp_mux: got %h expected %h", {dp_vid_empty, dp_cnt_empty, dp_vid, dp_cnt}, {2'b11, 16'h0000});
        end
        rst = 1'b0;
        tick;
        n_checks++;
        if ({busy, dp_rst_n, grant} !== 6'b0_1_0000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected %b", {busy, dp_rst_n, grant}, 6'b010000);
        end
    endtask

    task automatic test_single_packet;
        int v0, c0, d0;
        dp_vid_rd = 1'b1; dp_cnt_rd = 1'b1;
        v0 = vid_pops[0]; c0 = cnt_pops[0]; d0 = desc_pops[0];
        set_pend(0, 1, 16'h0301);
        #1;
        n_checks++;
        if (desc_rd !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_desc_rd: got %b expected 0001", desc_rd);
        end
        tick;   // first RUN cycle
        n_checks++;
        if ({grant, busy} !== 5'b0001_1) begin
            n_fail++;
            $display("FAIL single_grant: got %b expected 00011", {grant, busy});
        end
        n_checks++;
        if ({dp_vid, dp_cnt, dp_last_sign} !== {8'h40, 8'h80, 1'b1}) begin
            n_fail++;
            $display("FAIL single_forward: got %h expected %h", {dp_vid, dp_cnt, dp_last_sign}, {8'h40, 8'h80, 1'b1});
        end
        repeat (4) tick;    // fifth RUN cycle, both quotas consumed
        n_checks++;
        if (vid_pops[0] - v0 !== 4 || cnt_pops[0] - c0 !== 2) begin
            n_fail++;
            $display("FAIL single_pops: got vid %0d cnt %0d expected vid 4 cnt 2", vid_pops[0] - v0, cnt_pops[0] - c0);
        end
        n_checks++;
        if ({dp_vid_empty, dp_cnt_empty} !== 2'b11) begin
            n_fail++;
            $display("FAIL single_quota_empty: got %b expected 11", {dp_vid_empty, dp_cnt_empty});
        end
        repeat (4) tick;    // fourth DRAIN cycle
        n_checks++;
        if ({busy, dp_rst_n} !== 2'b11) begin
            n_fail++;
            $display("FAIL single_drain_len: got busy/rst_n %b expected 11", {busy, dp_rst_n});
        end
        tick;   // CLR
        n_checks++;
        if ({dp_rst_n, grant} !== 5'b0_0001) begin
            n_fail++;
            $display("FAIL single_clr: got rst_n/grant %b expected 00001", {dp_rst_n, grant});
        end
        tick;   // ARB
        n_checks++;
        if ({busy, dp_rst_n, grant} !== 6'b0_1_0000) begin
            n_fail++;
            $display("FAIL single_back_arb: got %b expected 010000", {busy, dp_rst_n, grant});
        end
        n_checks++;
        if (vid_pops[0] - v0 !== 4 || desc_pops[0] - d0 !== 1) begin
            n_fail++;
            $display("FAIL single_totals: got vid %0d desc %0d expected vid 4 desc 1", vid_pops[0] - v0, desc_pops[0] - d0);
        end
    endtask

    task automatic test_round_robin;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int exp_desc[N_CH] = '{2, 1, 1, 1};
        int d0[N_CH];
        int base;
        bit done;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        base = grant_q.size();
        for (int i = 0; i < N_CH; i++) d0[i] = desc_pops[i];
        set_pend(0, 2, 16'h0000);
        set_pend(1, 1, 16'h0000);
        set_pend(2, 1, 16'h0000);
        set_pend(3, 1, 16'h0000);
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            tick;
            if (!busy && desc_empty == 4'hF) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL rr_timeout: got busy %b expected all packets done within 200 cycles", busy);
        end
        n_checks++;
        if (grant_q.size() - base !== 5) begin
            n_fail++;
            $display("FAIL rr_grant_count: got %0d expected 5", grant_q.size() - base);
        end
        for (int k = 0; k < 5; k++) begin
            if (grant_q.size() > base + k) begin
                n_checks++;
                if (grant_q[base + k] !== exp_order[k]) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: got ch %0d expected ch %0d", k, grant_q[base + k], exp_order[k]);
                end
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            n_checks++;
            if (desc_pops[i] - d0[i] !== exp_desc[i]) begin
                n_fail++;
                $display("FAIL rr_desc_rd[%0d]: got %0d expected %0d", i, desc_pops[i] - d0[i], exp_desc[i]);
            end
        end
    endtask

    task automatic test_vid_stall;
        int v0, c0;
        bit done;
        v0 = vid_pops[1]; c0 = cnt_pops[1];
        set_pend(1, 1, 16'h0200);   // last grant was ch0 -> ch1 next
        tick;   // first RUN cycle
        for (int k = 0; k < 10; k++) begin
            vid_empty[1] = (k % 2 == 1);
            #1;
            if (vid_empty[1]) begin
                n_checks++;
                if (vid_rd[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_pop_while_empty[%0d]: got %b expected 0", k, vid_rd[1]);
                end
            end
            n_checks++;
            if (grant !== 4'b0010) begin
                n_fail++;
                $display("FAIL stall_grant_held[%0d]: got %b expected 0010", k, grant);
            end
            tick;
        end
        vid_empty[1] = 1'b0;
        done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            if (!busy) done = 1'b1;
            else tick;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL stall_timeout: got busy %b expected 0", busy);
        end
        n_checks++;
        if (vid_pops[1] - v0 !== 3 || cnt_pops[1] - c0 !== 1) begin
            n_fail++;
            $display("FAIL stall_pops: got vid %0d cnt %0d expected vid 3 cnt 1", vid_pops[1] - v0, cnt_pops[1] - c0);
        end
    endtask

    task automatic test_drain;
        set_pend(2, 1, 16'h0000);   // last grant was ch1 -> ch2 next
        tick;   // RUN cycle 1, both entries popped
        tick;   // RUN cycle 2, quotas exhausted
        dp_data_wr = 1'b1;
`ifdef REPLACER_ARB_TAG_EN
        n_checks++;
        if (out_ch !== 2'd2) begin
            n_fail++;
            $display("FAIL tag_run: got out_ch %0d expected 2", out_ch);
        end
`endif
        tick;   // DRAIN 1
        dp_data_wr = 1'b0;
        tick;   // DRAIN 2 (count 1)
        tick;   // DRAIN 3 (count 2)
        dp_data_wr = 1'b1;
`ifdef REPLACER_ARB_TAG_EN
        n_checks++;
        if (out_ch !== 2'd2) begin
            n_fail++;
            $display("FAIL tag_drain: got out_ch %0d expected 2", out_ch);
        end
`endif
        tick;   // count restarted at 0
        dp_data_wr = 1'b0;
        tick;   // 1
        tick;   // 2
        out_afull = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            n_checks++;
            if ({busy, dp_rst_n} !== 2'b11) begin
                n_fail++;
                $display("FAIL drain_afull_hold[%0d]: got busy/rst_n %b expected 11", k, {busy, dp_rst_n});
            end
        end
        out_afull = 1'b0;
        tick;   // 3
        n_checks++;
        if ({busy, dp_rst_n} !== 2'b11) begin
            n_fail++;
            $display("FAIL drain_restart: got busy/rst_n %b expected 11", {busy, dp_rst_n});
        end
        tick;   // fourth clean cycle -> CLR
        n_checks++;
        if ({dp_rst_n, grant} !== 5'b0_0100) begin
            n_fail++;
            $display("FAIL drain_clr: got rst_n/grant %b expected 00100", {dp_rst_n, grant});
        end
        tick;
        n_checks++;
        if ({busy, dp_rst_n, grant} !== 6'b0_1_0000) begin
            n_fail++;
            $display("FAIL drain_back_arb: got %b expected 010000", {busy, dp_rst_n, grant});
        end
    endtask

    task automatic test_reset_mid_run;
        set_pend(3, 1, 16'h0905);   // last grant was ch2 -> ch3 next
        tick;   // RUN cycle 1, cnt_rem 6 -> 5
        tick;   // RUN cycle 2, cnt_rem 5
        n_checks++;
        if (grant !== 4'b1000) begin
            n_fail++;
            $display("FAIL midrun_grant: got %b expected 1000", grant);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({dp_rst_n, vid_rd, cnt_rd} !== 9'b0) begin
            n_fail++;
            $display("FAIL midrun_rst_reads: got %b expected 0", {dp_rst_n, vid_rd, cnt_rd});
        end
        tick;
        n_checks++;
        if ({grant, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL midrun_arb: got grant/busy %b expected 00000", {grant, busy});
        end
        n_checks++;
        if ({desc_rd, vid_rd, cnt_rd, dp_rst_n} !== 13'b0) begin
            n_fail++;
            $display("FAIL midrun_quiet: got %b expected 0", {desc_rd, vid_rd, cnt_rd, dp_rst_n});
        end
        rst = 1'b0;
        tick;
        n_checks++;
        if ({busy, dp_rst_n, dp_vid_empty, dp_cnt_empty} !== 4'b0111) begin
            n_fail++;
            $display("FAIL midrun_release: got %b expected 0111", {busy, dp_rst_n, dp_vid_empty, dp_cnt_empty});
        end
    endtask

    initial begin
        test_reset;
        test_single_packet;
        test_round_robin;
        test_vid_stall;
        test_drain;
        test_reset_mid_run;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
